// File: rtl/multichannel_sample_packer.sv
// Packs CHANNELS serial samples into one wide AXI-Stream word with a single output register.
// Define SAMPLE_PACKER_SYNC_CHECK_EN to resynchronise on s_axis_sample_tuser and count misalignments.
module multichannel_sample_packer #(
    parameter int unsigned CHANNEL_WIDTH = 16,
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned OUTPUT_WIDTH  = CHANNEL_WIDTH * CHANNELS
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [CHANNEL_WIDTH-1:0] s_axis_sample_tdata,
    input  logic                     s_axis_sample_tvalid,
    output logic                     s_axis_sample_tready,
    input  logic                     s_axis_sample_tuser,
    output logic [OUTPUT_WIDTH-1:0]  m_axis_packed_tdata,
    output logic                     m_axis_packed_tvalid,
    input  logic                     m_axis_packed_tready,
    output logic                     sync_err,
    output logic [15:0]              sync_err_count
);

    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept_c, last_c, resync_c;
    logic [IDX_W-1:0]        lane_c;
    logic [OUTPUT_WIDTH-1:0] word_c;

    // Only the completing beat can stall, and only behind a full, non-draining output.
    assign s_axis_sample_tready = (idx_q != LAST_IDX) || !out_valid_q || m_axis_packed_tready;
    assign accept_c             = s_axis_sample_tvalid && s_axis_sample_tready;
    assign last_c               = (idx_q == LAST_IDX);

`ifdef SAMPLE_PACKER_SYNC_CHECK_EN
    assign resync_c = accept_c && s_axis_sample_tuser && (idx_q != '0);
`else
    logic unused_tuser;
    assign unused_tuser = s_axis_sample_tuser;
    assign resync_c     = 1'b0;
`endif

    // Accumulator, lane index and output register next-state.
    always_comb begin
        lane_c      = resync_c ? '0 : idx_q;
        word_c      = acc_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (IDX_W'(k) == lane_c) begin
                word_c[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] = s_axis_sample_tdata;
            end
        end
        if (out_valid_q && m_axis_packed_tready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            acc_d = word_c;
            if (resync_c) begin
                idx_d = IDX_W'(1);
            end else if (last_c) begin
                idx_d       = '0;
                out_data_d  = word_c;
                out_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m_axis_packed_tdata  = out_data_q;
    assign m_axis_packed_tvalid = out_valid_q;

`ifdef SAMPLE_PACKER_SYNC_CHECK_EN
    logic        sync_err_q, sync_err_d;
    logic [15:0] sync_cnt_q, sync_cnt_d;

    // Misalignment pulse and saturating counter.
    always_comb begin
        sync_err_d = resync_c;
        sync_cnt_d = sync_cnt_q;
        if (resync_c && (sync_cnt_q != 16'hFFFF)) begin
            sync_cnt_d = sync_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_err_q <= 1'b0;
            sync_cnt_q <= '0;
        end else begin
            sync_err_q <= sync_err_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    assign sync_err       = sync_err_q;
    assign sync_err_count = sync_cnt_q;
`else
    assign sync_err       = 1'b0;
    assign sync_err_count = '0;
`endif

endmodule

// File: tb/tb_multichannel_sample_packer.sv
// Directed bench for multichannel_sample_packer; inputs change on the falling edge, outputs sampled there too.
module tb_multichannel_sample_packer;

    localparam int unsigned CW = 16;
    localparam int unsigned NCH = 8;
    localparam int unsigned OW = CW * NCH;

    logic          aclk;
    logic          aresetn;
    logic [CW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tuser;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          sync_err;
    logic [15:0]   sync_err_count;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    multichannel_sample_packer #(
        .CHANNEL_WIDTH(CW),
        .CHANNELS     (NCH),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_axis_sample_tdata (s_tdata),
        .s_axis_sample_tvalid(s_tvalid),
        .s_axis_sample_tready(s_tready),
        .s_axis_sample_tuser (s_tuser),
        .m_axis_packed_tdata (m_tdata),
        .m_axis_packed_tvalid(m_tvalid),
        .m_axis_packed_tready(m_tready),
        .sync_err            (sync_err),
        .sync_err_count      (sync_err_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mkword(input logic [15:0] base);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = base + 16'(k);
        return w;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic beat(input logic [15:0] d, input logic u);
        int  n;
        logic r;
        n = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tvalid = 1'b1;
        forever begin
            #1 r = s_tready;
            @(posedge aclk);
            @(negedge aclk);
            if (r) break;
            n++;
            stalls++;
            if (n >= 50) begin
                check("beat_timeout", 128'(n), 128'(0));
                break;
            end
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         gap;
        logic         early;
        logic         sync_any;
        logic [127:0] exp_w;

        aresetn  = 1'b0;
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tdata  = '0;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_tdata", m_tdata, 128'(0));
        check("rst_s_ready", 128'(s_tready), 128'(1));
        check("rst_sync_err", 128'(sync_err), 128'(0));
        check("rst_sync_cnt", 128'(sync_err_count), 128'(0));
        aresetn = 1'b1;
        @(negedge aclk);

        // Straight pack
        m_tready = 1'b1;
        stalls   = 0;
        early    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(16'(i), i == 0);
            if (i < 7) early |= m_tvalid;
        end
        check("pack_no_early", 128'(early), 128'(0));
        check("pack_tvalid", 128'(m_tvalid), 128'(1));
        check("pack_tdata", m_tdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        check("pack_no_stall", 128'(stalls), 128'(0));
        idle();
        @(negedge aclk);
        check("pack_drained", 128'(m_tvalid), 128'(0));

        // Backpressure: 16 samples with downstream stalled
        m_tready = 1'b0;
        stalls   = 0;
        for (int i = 0; i < 15; i++) beat(16'h1000 + 16'(i), (i % 8) == 0);
        check("bp_no_stall_15", 128'(stalls), 128'(0));
        check("bp_word1_valid", 128'(m_tvalid), 128'(1));
        s_tdata  = 16'h100F;
        s_tuser  = 1'b0;
        s_tvalid = 1'b1;
        #1;
        check("bp_ready_low_16", 128'(s_tready), 128'(0));
        check("bp_word1_data", m_tdata, mkword(16'h1000));
        @(posedge aclk);
        @(negedge aclk);
        check("bp_word1_stable", m_tdata, mkword(16'h1000));
        check("bp_still_stalled", 128'(s_tready), 128'(0));
        m_tready = 1'b1;
        #1;
        check("bp_ready_comb", 128'(s_tready), 128'(1));
        @(posedge aclk);
        @(negedge aclk);
        check("bp_word2_valid", 128'(m_tvalid), 128'(1));
        check("bp_word2_data", m_tdata, mkword(16'h1008));
        idle();
        @(negedge aclk);
        check("bp_drained", 128'(m_tvalid), 128'(0));

        // Drain coinciding with a completing beat
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'h2000 + 16'(i), i == 0);
        check("sim_wordA", m_tdata, mkword(16'h2000));
        gap = 1'b0;
        for (int i = 8; i < 15; i++) begin
            beat(16'h2000 + 16'(i), i == 8);
            gap |= !m_tvalid;
        end
        m_tready = 1'b1;
        beat(16'h200F, 1'b0);
        gap |= !m_tvalid;
        check("sim_no_gap", 128'(gap), 128'(0));
        check("sim_wordB", m_tdata, mkword(16'h2008));
        idle();
        @(negedge aclk);
        check("sim_drained", 128'(m_tvalid), 128'(0));

        // Misaligned start marker
        early    = 1'b0;
        sync_any = 1'b0;
        for (int i = 0; i < 3; i++) beat(16'h3000 + 16'(i), i == 0);
        for (int i = 0; i < 8; i++) begin
            beat(16'hA000 + 16'(i), i == 0);
            sync_any |= sync_err;
`ifdef SAMPLE_PACKER_SYNC_CHECK_EN
            if (i == 0) check("rs_err_pulse", 128'(sync_err), 128'(1));
            if (i == 1) begin
                check("rs_err_cleared", 128'(sync_err), 128'(0));
                check("rs_count", 128'(sync_err_count), 128'(1));
            end
            if (i < 7) early |= m_tvalid;
            if (i == 7) begin
                check("rs_tvalid", 128'(m_tvalid), 128'(1));
                check("rs_tdata", m_tdata, mkword(16'hA000));
            end
`else
            if (i < 4) early |= m_tvalid;
            if (i == 4) begin
                exp_w = {16'hA004, 16'hA003, 16'hA002, 16'hA001,
                         16'hA000, 16'h3002, 16'h3001, 16'h3000};
                check("rs_tvalid", 128'(m_tvalid), 128'(1));
                check("rs_tdata", m_tdata, exp_w);
            end
`endif
        end
        check("rs_no_partial", 128'(early), 128'(0));
`ifndef SAMPLE_PACKER_SYNC_CHECK_EN
        check("rs_no_err", 128'(sync_any), 128'(0));
        check("rs_count_zero", 128'(sync_err_count), 128'(0));
        for (int i = 0; i < 5; i++) beat(16'hB000 + 16'(i), 1'b0);
        exp_w = {16'hB004, 16'hB003, 16'hB002, 16'hB001,
                 16'hB000, 16'hA007, 16'hA006, 16'hA005};
        check("rs_count_based", m_tdata, exp_w);
`endif
        idle();
        @(negedge aclk);

        // Reset with a pending word and a partial set
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'h4000 + 16'(i), i == 0);
        check("rm_pending", 128'(m_tvalid), 128'(1));
        for (int i = 8; i < 13; i++) beat(16'h4000 + 16'(i), i == 8);
        idle();
        aresetn = 1'b0;
        @(negedge aclk);
        check("rm_tvalid", 128'(m_tvalid), 128'(0));
        check("rm_tdata", m_tdata, 128'(0));
        check("rm_s_ready", 128'(s_tready), 128'(1));
        check("rm_sync_cnt", 128'(sync_err_count), 128'(0));
        aresetn  = 1'b1;
        m_tready = 1'b1;
        early    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(16'h5000 + 16'(i), i == 0);
            if (i < 7) early |= m_tvalid;
        end
        check("rm_no_early", 128'(early), 128'(0));
        check("rm_clean_word", m_tdata, mkword(16'h5000));
        idle();
        @(negedge aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multichannel_sample_packer.md
# multichannel_sample_packer

- Collects a serial stream of per-channel audio samples, one 16-bit sample per beat in channel order 0..CHANNELS-1.
- Packs each complete set into one wide AXI-Stream word, channel k at bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- Sits directly upstream of the real-to-complex interleave stage: its master port connects to that stage's 128-bit `s_axis_simple` input.
- Provides one word of output buffering so a full set can be held while the next set starts to accumulate.

## Interface
- `CHANNEL_WIDTH`, 16, bits per sample.
- `CHANNELS`, 8, samples per packed word.
- `OUTPUT_WIDTH`, CHANNEL_WIDTH*CHANNELS, packed word width.
- `aclk`  in  1  single clock; all logic rising-edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_sample_tdata`  in  CHANNEL_WIDTH  one sample.
- `s_axis_sample_tvalid`  in  1  sample valid.
- `s_axis_sample_tready`  out  1  sample accepted when valid&&ready.
- `s_axis_sample_tuser`  in  1  start-of-set marker, high on the channel-0 beat.
- `m_axis_packed_tdata`  out  OUTPUT_WIDTH  packed set.
- `m_axis_packed_tvalid`  out  1  packed word valid.
- `m_axis_packed_tready`  in  1  downstream accept.
- `sync_err`  out  1  one-cycle pulse on a detected misalignment.
- `sync_err_count`  out  16  saturating misalignment count.

## Operation
- **Accumulator:** holds an OUTPUT_WIDTH register plus a channel index `idx`, range 0..CHANNELS-1.
- **Accepted beat with idx < CHANNELS-1:** sample is written to lane `idx`; `idx` increments.
- **Accepted beat with idx == CHANNELS-1:**
  - The accumulator contents, with this sample in the top lane, load the output register.
  - `m_axis_packed_tvalid` is set and `idx` wraps to 0.
- **Output register:** one entry. It is cleared on `m_axis_packed_tvalid && m_axis_packed_tready` unless a new word loads in the same cycle; in that case the new word replaces it and valid stays 1.
- **Ready rule:** `s_axis_sample_tready = (idx != CHANNELS-1) || !m_axis_packed_tvalid || m_axis_packed_tready`.
  - Lanes 0..CHANNELS-2 are always accepted.
  - Only the completing beat stalls on a full, non-draining output register.
- **tdata stability:** output tdata holds stable while valid && !ready.
- **Lane contents:** unwritten lanes are never exposed, because a word leaves only after all CHANNELS lanes are written.
- **Arithmetic:** none. Samples pass bit-exact, with no sign extension.
- **Reset (aresetn low at a clock edge):**
  - `idx` = 0, partial set discarded.
  - `m_axis_packed_tvalid` = 0, `m_axis_packed_tdata` = 0.
  - `s_axis_sample_tready` = 1.
  - `sync_err` = 0, `sync_err_count` = 0.
  - A pending output word is dropped.

## Timing
- **Latency:** the completing sample accepted at edge N gives `m_axis_packed_tvalid` = 1 and the new tdata after edge N.
- **Throughput:** one sample per cycle sustained, provided the downstream accepts at least one word per CHANNELS cycles.
- **Combinational paths:** `s_axis_sample_tready` depends combinationally on `m_axis_packed_tready` (completing lane only). No other combinational input-to-output path exists.
- **Simultaneous events:** completing input beat plus output drain in the same cycle gives no bubble; the new word is valid on the next cycle.
- **Input gaps:** `s_axis_sample_tvalid` low holds `idx` and the accumulator unchanged.

## Configuration
- **Macro:** `SAMPLE_PACKER_SYNC_CHECK_EN`.
- **Defined:** `s_axis_sample_tuser` is checked on every accepted beat.
  - tuser=1 with idx≠0: the partial set is discarded. The beat is written as lane 0, `idx` becomes 1, `sync_err` pulses for one cycle, and `sync_err_count` increments, saturating at 0xFFFF.
  - tuser=0 with idx==0: the beat is accepted normally, with no error; only the start marker resynchronises.
  - Output register is unaffected by a resync.
- **Not defined:**
  - tuser is ignored.
  - Packing is purely count-based.
  - `sync_err` and `sync_err_count` are tied to 0.

## Test plan
- **Straight pack:** m_ready=1, feed 0x0000..0x0007 back-to-back, tuser on first → one word 0x0007_0006_0005_0004_0003_0002_0001_0000 one cycle after the last beat; s_ready stays 1.
- **Backpressure:**
  - Hold m_ready=0 and feed 16 samples → first word held stable and s_ready=0 on the 16th beat only.
  - Then raise m_ready → first word drains, second word valid the cycle after, with no sample lost.
- **Simultaneous drain and load:** m_ready toggled so a drain coincides with the completing beat → tvalid stays 1 continuously, tdata changes to the new word.
- **Resync (macro defined):** feed 3 samples, then tuser=1 with 0xA000..0xA007 → `sync_err` one pulse, count=1, output 0xA007_…_A000, with no partial word emitted.
- **Resync (macro undefined):** same stimulus → word packs lanes 0..2 from the first samples and lanes 3..7 from 0xA000..0xA004; `sync_err` stays 0.
- **Reset mid-set:**
  - Feed 5 samples with an output word pending, then pull aresetn low for 1 cycle → tvalid=0, tdata=0.
  - Next 8 samples form a clean word starting at lane 0.
